// File: rtl/wb_data_mem_slave.sv
// Pipelined Wishbone B4 responder for a core's data RAM: a small request FIFO followed by
// lane alignment, with err termination on misaligned, illegal-select or out-of-range accesses.
module wb_data_mem_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_wb_data,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int unsigned IW   = $clog2(DEPTH_WORDS);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t          fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic [31:0]   ram_r [DEPTH_WORDS];

    logic          push_s;
    logic          pop_s;
    req_t          head_s;
    logic [31:0]   off_s;
    logic          in_range_s;
    logic [IW-1:0] idx_s;
    logic [1:0]    b_s;
    logic [4:0]    shift_s;
    logic          sel_ok_s;
    logic [31:0]   mask_s;
    logic          err_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;
    logic [31:0]   rdata_s;

    assign o_wb_stall = (count_r == FULL);
    assign push_s     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign pop_s      = i_wb_cyc & (count_r != '0);

    // Request storage; entries are only meaningful while counted
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= '{we: i_wb_we, sel: i_wb_sel, addr: i_wb_addr, data: i_wb_data};
        end
    end

    // FIFO pointers and occupancy; dropping cyc discards everything queued
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (!i_wb_cyc) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Decode of the head entry: range, size/alignment legality and lane steering
    always_comb begin
        head_s     = fifo_mem_r[rd_ptr_r];
        off_s      = head_s.addr - BASE_ADDR;
        in_range_s = (head_s.addr >= BASE_ADDR) && (off_s < SPAN);
        idx_s      = off_s[IW+1:2];
        b_s        = head_s.addr[1:0];
        shift_s    = {b_s, 3'b000};
        case (head_s.sel)
            4'b0001: begin
                sel_ok_s = 1'b1;
                mask_s   = 32'h0000_00FF;
            end
            4'b0011: begin
                sel_ok_s = ~b_s[0];
                mask_s   = 32'h0000_FFFF;
            end
            4'b1111: begin
                sel_ok_s = (b_s == 2'b00);
                mask_s   = 32'hFFFF_FFFF;
            end
            default: begin
                sel_ok_s = 1'b0;
                mask_s   = 32'h0000_0000;
            end
        endcase
        err_s   = ~in_range_s | ~sel_ok_s;
        be_s    = head_s.sel << b_s;
        wdata_s = head_s.data << shift_s;
        rdata_s = (ram_r[idx_s] >> shift_s) & mask_s;
    end

    // RAM byte-lane writes; errored and flushed requests never reach here
    always_ff @(posedge i_clk) begin
        if (pop_s && !err_s && head_s.we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    ram_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Registered response: exactly one of ack/err per issued request
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= 32'h0000_0000;
        end else if (pop_s) begin
            o_wb_ack  <= ~err_s;
            o_wb_err  <= err_s;
            o_wb_data <= (err_s || head_s.we) ? 32'h0000_0000 : rdata_s;
        end else begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= o_wb_data;
        end
    end

endmodule
